// File: rtl/controlador_matrizes.sv
// Sequences C = A+B, A-B, A*B or transpose(A) over a 3x5x5 matrix memory with a registered read port.
// Per element: 4 cycles add/sub, 3 transpose, 16 mult; the host port is muxed through only while idle.
module controlador_matrizes #(
   parameter int DATA_W = 16,
   parameter int DIM    = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [1:0]        op,
   output logic              ocupado,
   output logic              done,
   output logic              host_grant,
   input  logic              host_we,
   input  logic              host_re,
   input  logic [1:0]        host_id,
   input  logic [2:0]        host_linha,
   input  logic [2:0]        host_coluna,
   input  logic [DATA_W-1:0] host_dado_in,
   output logic              mem_we,
   output logic              mem_re,
   output logic [1:0]        mem_id,
   output logic [2:0]        mem_linha,
   output logic [2:0]        mem_coluna,
   output logic [DATA_W-1:0] mem_dado_in,
   input  logic [DATA_W-1:0] mem_dado_out
);

   typedef enum logic [2:0] {IDLE, RD_A, RD_B, ACC, WR, DONE} state_t;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_MUL = 2'b10;
   localparam logic [1:0] OP_TRN = 2'b11;
   localparam logic [2:0] LAST   = 3'(DIM - 1);

   state_t state, state_nxt;
   logic [1:0]        op_reg;
   logic [2:0]        i, j, k;
   logic [DATA_W-1:0] a_reg, acc;
   logic signed [DATA_W-1:0] prod;

   logic       fsm_we, fsm_re;
   logic [1:0] fsm_id;
   logic [2:0] fsm_linha, fsm_coluna;

   // Only the low DATA_W bits of the product are kept before accumulation.
   assign prod = $signed(a_reg) * $signed(mem_dado_out);

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      fsm_we     = 1'b0;
      fsm_re     = 1'b0;
      fsm_id     = 2'b00;
      fsm_linha  = i;
      fsm_coluna = j;
      case (state)
         IDLE: if (start) state_nxt = RD_A;
         RD_A: begin
            fsm_re = 1'b1;
            fsm_id = 2'b00;
            if (op_reg == OP_MUL) begin
               fsm_coluna = k;
            end else if (op_reg == OP_TRN) begin
               fsm_linha  = j;
               fsm_coluna = i;
            end
            state_nxt = (op_reg == OP_TRN) ? ACC : RD_B;
         end
         RD_B: begin
            fsm_re = 1'b1;
            fsm_id = 2'b01;
            if (op_reg == OP_MUL) fsm_linha = k;
            state_nxt = ACC;
         end
         ACC: state_nxt = (op_reg == OP_MUL && k != LAST) ? RD_A : WR;
         WR: begin
            fsm_we    = 1'b1;
            fsm_id    = 2'b10;
            state_nxt = (i == LAST && j == LAST) ? DONE : RD_A;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         op_reg <= OP_ADD;
         i      <= '0;
         j      <= '0;
         k      <= '0;
         a_reg  <= '0;
         acc    <= '0;
      end else begin
         case (state)
            IDLE: if (start) begin
               op_reg <= op;
               i      <= '0;
               j      <= '0;
               k      <= '0;
            end
            RD_B: a_reg <= mem_dado_out;
            ACC: begin
               unique case (op_reg)
                  OP_ADD: acc <= a_reg + mem_dado_out;
                  OP_SUB: acc <= a_reg - mem_dado_out;
                  OP_TRN: acc <= mem_dado_out;
                  OP_MUL: acc <= ((k == 3'd0) ? '0 : acc) + $unsigned(prod);
               endcase
               if (op_reg == OP_MUL && k != LAST) k <= k + 3'd1;
            end
            WR: begin
               k <= '0;
               if (j == LAST) begin
                  j <= '0;
                  i <= i + 3'd1;
               end else begin
                  j <= j + 3'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign ocupado    = (state != IDLE);
   assign host_grant = (state == IDLE);
   assign done       = (state == DONE);

   assign mem_we      = host_grant ? host_we      : fsm_we;
   assign mem_re      = host_grant ? host_re      : fsm_re;
   assign mem_id      = host_grant ? host_id      : fsm_id;
   assign mem_linha   = host_grant ? host_linha   : fsm_linha;
   assign mem_coluna  = host_grant ? host_coluna  : fsm_coluna;
   assign mem_dado_in = host_grant ? host_dado_in : acc;

endmodule

// File: tb/tb_controlador_matrizes.sv
// Bench for controlador_matrizes: owns the 3x5x5 memory, loads A/B through the host port,
// and scoreboards C writes and host readbacks against a matrix-arithmetic reference.
module tb_controlador_matrizes;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [1:0]  op = 2'b00;
   logic        ocupado, done, host_grant;
   logic        host_we = 1'b0, host_re = 1'b0;
   logic [1:0]  host_id = 2'b00;
   logic [2:0]  host_linha = 3'd0, host_coluna = 3'd0;
   logic [15:0] host_dado_in = 16'h0;
   logic        mem_we, mem_re;
   logic [1:0]  mem_id;
   logic [2:0]  mem_linha, mem_coluna;
   logic [15:0] mem_dado_in;
   logic [15:0] mem_dado_out = 16'h0;

   always #5 clk = ~clk;

   controlador_matrizes #(.DATA_W(16), .DIM(5)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op(op),
      .ocupado(ocupado), .done(done), .host_grant(host_grant),
      .host_we(host_we), .host_re(host_re), .host_id(host_id),
      .host_linha(host_linha), .host_coluna(host_coluna), .host_dado_in(host_dado_in),
      .mem_we(mem_we), .mem_re(mem_re), .mem_id(mem_id),
      .mem_linha(mem_linha), .mem_coluna(mem_coluna),
      .mem_dado_in(mem_dado_in), .mem_dado_out(mem_dado_out)
   );

   // Matrix memory with a registered read port.
   logic [15:0] mem [3][5][5];
   always @(posedge clk) begin
      if (mem_we && mem_id != 2'b11 && mem_linha < 3'd5 && mem_coluna < 3'd5)
         mem[mem_id][mem_linha][mem_coluna] <= mem_dado_in;
      if (mem_re && mem_id != 2'b11 && mem_linha < 3'd5 && mem_coluna < 3'd5)
         mem_dado_out <= mem[mem_id][mem_linha][mem_coluna];
   end

   int total = 0;
   int bad = 0;
   logic [15:0] ra [5][5];
   logic [15:0] rb [5][5];
   logic [15:0] rc [5][5];
   logic [15:0] exp_q [$];
   logic [23:0] wr_q [$];
   int busy_cnt = 0, done_cnt = 0, wr_cnt = 0, rdb_cnt = 0;
   logic rd_vld = 1'b0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", name, got, want);
      end
   endtask

   // Reference: C computed directly from the matrix definitions, wrapped to 16 bits.
   function automatic logic [15:0] ref_c(input logic [1:0] o, input int i, input int j);
      longint s;
      s = 0;
      case (o)
         2'b00: s = longint'(ra[i][j]) + longint'(rb[i][j]);
         2'b01: s = longint'(ra[i][j]) - longint'(rb[i][j]);
         2'b10: for (int m = 0; m < 5; m++)
                   s += longint'($signed(ra[i][m])) * longint'($signed(rb[m][j]));
         default: s = longint'(ra[j][i]);
      endcase
      return s[15:0];
   endfunction

   function automatic int busy_of(input logic [1:0] o);
      if (o == 2'b10) return 25 * 16 + 1;
      if (o == 2'b11) return 25 * 3 + 1;
      return 25 * 4 + 1;
   endfunction

   always @(posedge clk) rd_vld <= mem_re & host_grant;

   // Monitor: host readbacks, C writes and busy/done bookkeeping.
   always @(negedge clk) begin
      if (rd_vld) begin
         if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL rd_unexpected got=%0h want=none", mem_dado_out);
         end else begin
            chk("readback", {16'h0, mem_dado_out}, {16'h0, exp_q.pop_front()});
         end
      end
      if (done) done_cnt++;
      if (ocupado) begin
         busy_cnt++;
         if (mem_re && mem_id == 2'b01) rdb_cnt++;
         if (mem_we) begin
            wr_cnt++;
            if (wr_q.size() == 0) begin
               total++; bad++;
               $display("FAIL wr_unexpected got=%0h want=none",
                        {mem_id, mem_linha, mem_coluna, mem_dado_in});
            end else begin
               chk("c_write", {8'h0, mem_id, mem_linha, mem_coluna, mem_dado_in},
                   {8'h0, wr_q.pop_front()});
            end
         end
      end
   end

   task automatic hw(input logic [1:0] id, input int l, input int c, input logic [15:0] d);
      @(negedge clk);
      host_we = 1'b1; host_id = id; host_linha = 3'(l); host_coluna = 3'(c); host_dado_in = d;
   endtask

   task automatic load_ab();
      for (int i = 0; i < 5; i++)
         for (int j = 0; j < 5; j++) begin
            hw(2'b00, i, j, ra[i][j]);
            hw(2'b01, i, j, rb[i][j]);
         end
      @(negedge clk); host_we = 1'b0;
   endtask

   task automatic rd(input logic [1:0] id, input int l, input int c, input logic [15:0] e);
      @(negedge clk);
      host_re = 1'b1; host_id = id; host_linha = 3'(l); host_coluna = 3'(c);
      exp_q.push_back(e);
   endtask

   task automatic rd_end();
      @(negedge clk); host_re = 1'b0;
      @(negedge clk);
      chk("rd_drained", exp_q.size(), 0);
   endtask

   task automatic run_op(input logic [1:0] o, input int abort_at, input bit poke);
      int c;
      for (int i = 0; i < 5; i++)
         for (int j = 0; j < 5; j++) begin
            rc[i][j] = ref_c(o, i, j);
            wr_q.push_back({2'b10, 3'(i), 3'(j), rc[i][j]});
         end
      busy_cnt = 0; done_cnt = 0; wr_cnt = 0; rdb_cnt = 0;
      @(negedge clk); start = 1'b1; op = o;
      @(negedge clk); start = 1'b0;
      c = 1;
      while (ocupado && c < 2000) begin
         if (poke && c == 20) begin
            start = 1'b1; host_we = 1'b1; host_id = 2'b00;
            host_linha = 3'd0; host_coluna = 3'd0; host_dado_in = 16'hDEAD;
         end
         if (poke && c == 23) begin
            start = 1'b0; host_we = 1'b0;
         end
         if (abort_at != 0 && c == abort_at) begin
            rst_n = 1'b0;
            @(negedge clk);
            chk("abort_idle_next", ocupado, 0);
            break;
         end
         @(negedge clk); c++;
      end
      chk("op_finished", ocupado, 0);
      if (abort_at != 0) begin
         chk("abort_grant", host_grant, 1);
         chk("abort_no_done", done_cnt, 0);
         rst_n = 1'b1;
         wr_q.delete();
         @(negedge clk);
      end else begin
         chk("busy_cycles", busy_cnt, busy_of(o));
         chk("done_pulses", done_cnt, 1);
         chk("c_write_count", wr_cnt, 25);
         chk("c_write_pending", wr_q.size(), 0);
         if (o == 2'b11) chk("trn_no_b_reads", rdb_cnt, 0);
         for (int i = 0; i < 5; i++)
            for (int j = 0; j < 5; j++) rd(2'b10, i, j, rc[i][j]);
         rd_end();
      end
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_ocupado", ocupado, 0);
      chk("rst_done", done, 0);
      chk("rst_grant", host_grant, 1);
      rst_n = 1'b1;

      for (int i = 0; i < 5; i++) for (int j = 0; j < 5; j++) begin
         ra[i][j] = 16'(5 * i + j); rb[i][j] = 16'd2;
      end
      load_ab(); run_op(2'b00, 0, 0);

      for (int i = 0; i < 5; i++) for (int j = 0; j < 5; j++) rb[i][j] = 16'd7;
      load_ab(); run_op(2'b01, 0, 0);
      rd(2'b10, 0, 0, 16'hFFF9); rd(2'b10, 4, 4, 16'h0011); rd_end();

      for (int i = 0; i < 5; i++) for (int j = 0; j < 5; j++) begin
         ra[i][j] = (i == j) ? 16'd1 : 16'd0; rb[i][j] = 16'(10 * i + j);
      end
      load_ab(); run_op(2'b10, 0, 0);
      for (int i = 0; i < 5; i++) for (int j = 0; j < 5; j++) begin
         ra[i][j] = 16'd1; rb[i][j] = 16'd3;
      end
      load_ab(); run_op(2'b10, 0, 0);
      rd(2'b10, 2, 3, 16'd15); rd_end();

      for (int i = 0; i < 5; i++) for (int j = 0; j < 5; j++) ra[i][j] = 16'(5 * i + j);
      load_ab(); run_op(2'b11, 0, 0);
      rd(2'b10, 1, 3, 16'd16); rd_end();

      for (int i = 0; i < 5; i++) for (int j = 0; j < 5; j++) begin
         ra[i][j] = 16'h7FFF; rb[i][j] = 16'h0002;
      end
      load_ab(); run_op(2'b00, 0, 0);
      rd(2'b10, 3, 1, 16'h8001); rd_end();
      for (int i = 0; i < 5; i++) for (int j = 0; j < 5; j++) begin
         ra[i][j] = 16'h0100; rb[i][j] = 16'h0100;
      end
      load_ab(); run_op(2'b10, 0, 0);

      // Start and host write asserted mid-operation must both be ignored.
      for (int i = 0; i < 5; i++) for (int j = 0; j < 5; j++) begin
         ra[i][j] = 16'(5 * i + j); rb[i][j] = 16'(3 * j);
      end
      load_ab(); run_op(2'b00, 0, 1);
      rd(2'b00, 0, 0, ra[0][0]); rd_end();

      run_op(2'b10, 50, 0);
      run_op(2'b01, 0, 0);

      for (int n = 0; n < 4; n++) begin
         for (int i = 0; i < 5; i++) for (int j = 0; j < 5; j++) begin
            ra[i][j] = 16'($urandom); rb[i][j] = 16'($urandom);
         end
         load_ab(); run_op(2'($urandom_range(0, 3)), 0, 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
